rst_sequencer: RTL

Downstream of the reset extender: takes the extended, glitch-free reset and releases NUM_DOM domain resets one at a time in ascending index order. Each release is spaced by a programmable gap. Each domain must acknowledge initialisation before the next one is released, and a watchdog flags a domain that never becomes ready. It is the last reset stage before the bridge datapath blocks.

---
 rtl/rst_sequencer_pkg.sv | 23 ++
 rtl/rst_sequencer_if.sv | 29 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/rst_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rst_sequencer_pkg.sv
// rtl/rst_sequencer_pkg.sv - shared state encoding, defaults and counter sizing for the reset sequencer
package rst_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } rst_state_t;

    localparam int RST_GAP_DEFAULT     = 8;
    localparam int RST_TIMEOUT_DEFAULT = 64;

    // One counter serves both the gap and the watchdog, so it is sized for the larger reload.
    function automatic int rst_cnt_width(input int gap, input int timeout);
        int m;
        m = (gap > timeout) ? gap : timeout;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - domain reset/ready and status bundle between sequencer and reset domains
interface rst_sequencer_if #(
    parameter int NUM_DOM = 4
);
    logic               sw_rst_req;
    logic [NUM_DOM-1:0] dom_ready;
    logic [NUM_DOM-1:0] dom_rst_n;
    logic               seq_done;
    logic               seq_err;
    logic [2:0]         err_dom;

    modport master (
        input  sw_rst_req,
        input  dom_ready,
        output dom_rst_n,
        output seq_done,
        output seq_err,
        output err_dom
    );

    modport slave (
        output sw_rst_req,
        output dom_ready,
        input  dom_rst_n,
        input  seq_done,
        input  seq_err,
        input  err_dom
    );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, async active-low reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - ordered domain reset release; ready handshake and watchdog under RST_SEQ_READY_EN
module rst_sequencer
    import rst_pkg::*;
#(
    parameter int NUM_DOM    = 4,
    parameter int GAP_CYCLES = RST_GAP_DEFAULT,
    parameter int TIMEOUT    = RST_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n_in,
    rst_sequencer_if.master bus
);
    localparam int                 CW       = rst_cnt_width(GAP_CYCLES, TIMEOUT);
    localparam logic [CW-1:0]      GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]      TO_LOAD  = CW'(TIMEOUT - 1);
    localparam logic [2:0]         LAST_IDX = 3'(NUM_DOM - 1);
    localparam logic [NUM_DOM-1:0] ONE_HOT0 = NUM_DOM'(1);

    rst_state_t         r_state;
    logic [2:0]         r_idx;
    logic [CW-1:0]      r_cnt;
    logic [NUM_DOM-1:0] r_dom_rst_n;
    logic               r_seq_done;
    logic               w_rdy;

`ifdef RST_SEQ_READY_EN
    logic               r_seq_err;
    logic [2:0]         r_err_dom;
    logic [NUM_DOM-1:0] w_ready_sync;
    logic [7:0]         w_ready_pad;

    for (genvar g = 0; g < NUM_DOM; g++) begin : g_sync
        sync_2ff u_sync (
            .clk   (clk),
            .rst_n (rst_n_in),
            .i_d   (bus.dom_ready[g]),
            .o_q   (w_ready_sync[g])
        );
    end

    assign w_ready_pad = 8'(w_ready_sync);
    assign w_rdy       = w_ready_pad[r_idx];
`else
    logic w_unused_ready;
    assign w_unused_ready = ^bus.dom_ready;
    assign w_rdy          = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_HOLD;
            r_idx       <= 3'd0;
            r_cnt       <= GAP_LOAD;
            r_dom_rst_n <= '0;
            r_seq_done  <= 1'b0;
`ifdef RST_SEQ_READY_EN
            r_seq_err   <= 1'b0;
            r_err_dom   <= 3'd0;
`endif
        end else if (bus.sw_rst_req && (r_state != ST_HOLD)) begin
            // Soft reset outranks any ready or timeout event in the same cycle.
            r_state     <= ST_HOLD;
            r_idx       <= 3'd0;
            r_cnt       <= GAP_LOAD;
            r_dom_rst_n <= '0;
            r_seq_done  <= 1'b0;
`ifdef RST_SEQ_READY_EN
            r_seq_err   <= 1'b0;
            r_err_dom   <= 3'd0;
`endif
        end else begin
            case (r_state)
                ST_HOLD, ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_dom_rst_n <= r_dom_rst_n | (ONE_HOT0 << r_idx);
                    r_cnt       <= TO_LOAD;
                    r_state     <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    if (w_rdy) begin
                        if (r_idx == LAST_IDX) begin
                            r_state    <= ST_DONE;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_state <= ST_GAP;
                            r_cnt   <= GAP_LOAD;
                            r_idx   <= r_idx + 3'd1;
                        end
`ifdef RST_SEQ_READY_EN
                    end else if (r_cnt == '0) begin
                        r_state   <= ST_ERR;
                        r_seq_err <= 1'b1;
                        r_err_dom <= r_idx;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign bus.dom_rst_n = r_dom_rst_n;
    assign bus.seq_done  = r_seq_done;
`ifdef RST_SEQ_READY_EN
    assign bus.seq_err   = r_seq_err;
    assign bus.err_dom   = r_err_dom;
`else
    assign bus.seq_err   = 1'b0;
    assign bus.err_dom   = 3'd0;
`endif
endmodule
